// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// sequencer state encoding and small op-decoding helpers.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Final result shaping: turns unsigned magnitudes into the {HI,LO} value,
// applying sign corrections and the divide-by-zero convention.
module mdu_signfix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   a_raw,
  input  logic [WIDTH-1:0]   hi_mag,
  input  logic [WIDTH-1:0]   lo_mag,
  output logic [2*WIDTH-1:0] hilo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  always_comb begin
    prod    = {hi_mag, lo_mag};
    rem_fix = neg_rem ? -hi_mag : hi_mag;
    quo_fix = neg_res ? -lo_mag : lo_mag;
    hilo    = prod;
    if (op_is_div(op) && div_zero) begin
      hilo = {a_raw, {WIDTH{1'b1}}};
    end else if (op == MDU_MULT && neg_res) begin
      hilo = -prod;
    end else if (op == MDU_DIV) begin
      hilo = {rem_fix, quo_fix};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide sequencer: shift-add multiply and
// restoring divide sharing one adder, with start/busy/valid/cancel handshake.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] hilo_out
);

  mdu_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] hilo_q, hilo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   add_x, add_y, add_sum;
  logic               add_cin;
  logic [WIDTH-1:0]   hi_step, lo_step;
  logic [2*WIDTH-1:0] hilo_fix;

  assign a_neg = op_is_signed(op) && a[WIDTH-1];
  assign b_neg = op_is_signed(op) && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One adder serves both: add multiplicand for multiply, subtract divisor for divide.
  always_comb begin
    if (op_is_div(op_q)) begin
      add_x   = {1'b0, hi_q, lo_q[WIDTH-1]};
      add_y   = ~{2'b00, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {2'b00, hi_q};
      add_y   = lo_q[0] ? {2'b00, opnd_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    if (op_is_div(op_q)) begin
      if (!add_sum[WIDTH+1]) begin
        hi_step = add_sum[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = add_sum[WIDTH:1];
      lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op       (op_q),
    .neg_res  (neg_res_q),
    .neg_rem  (neg_rem_q),
    .div_zero (div_zero_q),
    .a_raw    (araw_q),
    .hi_mag   (hi_step),
    .lo_mag   (lo_step),
    .hilo     (hilo_fix)
  );

  // The result is registered on the edge into DONE, so a cancel seen on that edge suppresses it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    araw_d     = araw_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    valid_d    = 1'b0;
    hilo_d     = hilo_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d    = CALC;
          op_d       = op;
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = op_is_div(op) ? a_mag : b_mag;
          opnd_d     = op_is_div(op) ? b_mag : a_mag;
          araw_d     = a;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (b == '0);
        end
      end
      CALC: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          hilo_d  = hilo_fix;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (cancel) begin
      state_d = IDLE;
      valid_d = 1'b0;
      hilo_d  = hilo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      araw_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
      hilo_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      araw_q     <= araw_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      valid_q    <= valid_d;
      hilo_q     <= hilo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign hilo_out = hilo_q;

endmodule
